// File: rtl/udp_tx_fifo_sched.sv
// udp_tx_fifo_sched: round-robin packet scheduler between NUM_CH FWFT TX FIFOs
// and a UDP transmit stack. A channel is granted only when it holds a whole
// packet. The scheduler then requests a send and drains exactly PKT_WORDS words
// from that channel. Everything runs in the FIFO read clock domain.
// Optional feature macro: UDP_TX_SCHED_TIMEOUT_EN (bounded wait for udp_tx_ready).
module udp_tx_fifo_sched #(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int PKT_WORDS      = 256,
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               rd_clk,
  input  logic                               rd_rst_n,
  input  logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   fifo_rd_water_level,
  input  logic [NUM_CH-1:0]                  fifo_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       fifo_rd_data,
  output logic [NUM_CH-1:0]                  fifo_rd_en,
  input  logic [NUM_CH-1:0]                  ch_enable,
  output logic                               udp_tx_req,
  output logic [15:0]                        udp_tx_len,
  output logic [2:0]                         udp_tx_ch,
  input  logic                               udp_tx_ready,
  input  logic                               udp_tx_data_req,
  output logic [DATA_WIDTH-1:0]              udp_tx_data,
  output logic                               busy,
  output logic                               timeout
);

  localparam int LVL_W      = ADDR_WIDTH + 1;
  localparam int LEN_BYTES  = PKT_WORDS * DATA_WIDTH / 8;
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam logic [LVL_W-1:0] PKT_LVL  = LVL_W'(PKT_WORDS);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [15:0]      LEN16    = LEN_BYTES[15:0];

  // Elaboration-time sanity checks on the configuration
  if (LEN_BYTES > 65535) begin : g_len_chk
    $error("udp_tx_fifo_sched: PKT_WORDS*DATA_WIDTH/8 exceeds 16-bit length");
  end
  if (NUM_CH < 2 || NUM_CH > 8) begin : g_ch_chk
    $error("udp_tx_fifo_sched: NUM_CH must be 2..8");
  end
  if (PKT_WORDS < 1 || PKT_WORDS > (1 << ADDR_WIDTH)) begin : g_pkt_chk
    $error("udp_tx_fifo_sched: PKT_WORDS out of range");
  end
  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_cyc_chk
    $error("udp_tx_fifo_sched: GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_REQ  = 3'd2,
    S_SEND = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       rr_q, rr_d;
  logic [2:0]       ch_q, ch_d;
  logic             req_q, req_d;
  logic [LVL_W-1:0] word_q, word_d;
  logic [GAP_W-1:0] gap_q, gap_d;

`ifdef UDP_TX_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;
`endif

  logic [NUM_CH-1:0]     elig;
  logic                  found;
  logic [2:0]            pick;
  logic [3:0]            idx;
  logic                  gnt_empty;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  pop;

  // A channel is eligible when enabled and holding at least one full packet
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++)
      elig[i] = ch_enable[i] && (fifo_rd_water_level[i*LVL_W +: LVL_W] >= PKT_LVL);
  end

  // First eligible channel at or above the rr pointer, wrapping to 0
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, rr_q} + 4'(k);
      if (idx >= 4'(NUM_CH)) idx = idx - 4'(NUM_CH);
      if (!found && elig[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  // Mux out the granted channel's empty flag and FWFT head word
  always_comb begin
    gnt_empty = 1'b1;
    gnt_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == 3'(i)) begin
        gnt_empty = fifo_empty[i];
        gnt_data  = fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Scheduler next-state: arbitration, request handshake, drain, gap
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    req_d   = req_q;
    word_d  = word_q;
    gap_d   = gap_q;
    pop     = 1'b0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: if (|elig) state_d = S_ARB;
      S_ARB: begin
        if (found) begin
          ch_d    = pick;
          rr_d    = (pick == 3'(NUM_CH - 1)) ? 3'd0 : pick + 3'd1;
          req_d   = 1'b1;
          state_d = S_REQ;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (udp_tx_ready) begin
          req_d   = 1'b0;
          word_d  = PKT_LVL;
          state_d = S_SEND;
        end
`ifdef UDP_TX_SCHED_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          // Stack never answered: give up on this grant, rr has already moved on
          req_d     = 1'b0;
          timeout_d = 1'b1;
          gap_d     = GAP_LOAD;
          state_d   = S_GAP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_SEND: begin
        // A pull against an empty FIFO just stalls; nothing is counted
        if (udp_tx_data_req && !gnt_empty) begin
          pop    = 1'b1;
          word_d = word_q - LVL_W'(1);
          if (word_q == LVL_W'(1)) begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(1)) state_d = S_IDLE;
        else                    gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      ch_q    <= '0;
      req_q   <= 1'b0;
      word_q  <= '0;
      gap_q   <= '0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      req_q   <= req_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Pop strobe goes only to the granted channel
  always_comb begin
    fifo_rd_en = '0;
    for (int i = 0; i < NUM_CH; i++)
      fifo_rd_en[i] = pop && (ch_q == 3'(i));
  end

  assign udp_tx_req  = req_q;
  assign udp_tx_len  = LEN16;
  assign udp_tx_ch   = ch_q;
  assign udp_tx_data = (state_q == S_SEND) ? gnt_data : '0;
  assign busy        = (state_q != S_IDLE);
`ifdef UDP_TX_SCHED_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_udp_tx_fifo_sched.sv
// Directed bench for udp_tx_fifo_sched with a small FWFT FIFO model per channel.
module tb_udp_tx_fifo_sched;
  localparam int NCH = 4, DW = 32, AW = 10, LW = AW + 1, PKT = 256, GAP = 12;

  logic              rd_clk = 1'b0;
  logic              rd_rst_n;
  logic [NCH*LW-1:0] lvl;
  logic [NCH-1:0]    empty;
  logic [NCH*DW-1:0] rd_data;
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    ch_enable;
  logic              req;
  logic [15:0]       len;
  logic [2:0]        ch;
  logic              ready, dreq;
  logic [DW-1:0]     data;
  logic              busy, timeout;

  int n_vec = 0, n_err = 0;
  int unsigned fifo_ptr [NCH] = '{default: 0};
  int unsigned exp_ptr  [NCH] = '{default: 0};

  udp_tx_fifo_sched #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PKT_WORDS(PKT),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16)
  ) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_rd_water_level(lvl),
    .fifo_empty(empty), .fifo_rd_data(rd_data), .fifo_rd_en(en),
    .ch_enable(ch_enable), .udp_tx_req(req), .udp_tx_len(len), .udp_tx_ch(ch),
    .udp_tx_ready(ready), .udp_tx_data_req(dreq), .udp_tx_data(data),
    .busy(busy), .timeout(timeout)
  );

  always #5 rd_clk = ~rd_clk;

  // FWFT model: head word = {channel, word index}, advanced by each pop
  always @(posedge rd_clk)
    for (int c = 0; c < NCH; c++)
      if (en[c]) fifo_ptr[c] <= fifo_ptr[c] + 1;

  for (genvar g = 0; g < NCH; g++) begin : g_data
    assign rd_data[g*DW +: DW] = (32'(g) << 24) | (fifo_ptr[g] & 32'h00FF_FFFF);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lvl(input int c, input int v);
    lvl[c*LW +: LW] = LW'(v);
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_rd_en"}, en, 0);
    check({tag, "_req"}, req, 0);
    check({tag, "_ch"}, ch, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // One packet: wait for the request, answer after 3 cycles, drain, check gap.
  // mode 0: data_req held high; mode 1: data_req toggles and empty pulses.
  // abort_at >= 0: pull reset after that many words have been popped.
  task automatic do_packet(input int exp_ch, input int mode, input int abort_at,
                           input bit zero_lvls, output int wait_n);
    int pops, g, bad, n;
    bit dr, em, ok;
    wait_n = 0;
    while (!req && wait_n < 20) begin
      @(negedge rd_clk); #1; wait_n++;
    end
    check("req_seen", req, 1);
    check("grant_ch", ch, exp_ch);
    check("tx_len", len, 16'd1024);
    dreq = 1'b1; empty = '0;
    repeat (3) begin
      @(negedge rd_clk); #1;
      check("req_hold", req, 1);
      check("no_pop_in_req", en, 0);
    end
    @(negedge rd_clk); ready = 1'b1; #1;
    check("no_pop_on_ready", en, 0);
    pops = 0; n = 0;
    while (pops < PKT && n < 3000) begin
      @(negedge rd_clk);
      ready = 1'b0;
      if (abort_at >= 0 && pops == abort_at) begin
        rd_rst_n = 1'b0; #1;
        check_zero_outs("mid_rst");
        lvl = '0; dreq = 1'b0;
        @(negedge rd_clk); rd_rst_n = 1'b1;
        @(negedge rd_clk); #1;
        check("post_rst_busy", busy, 0);
        return;
      end
      dr = (mode == 0) ? 1'b1 : n[0];
      em = (mode == 1) && (n % 7 == 3);
      dreq  = dr;
      empty = em ? (4'b1 << exp_ch) : 4'b0;
      #1;
      if (n == 0) check("req_drop", req, 0);
      ok = dr && !em;
      check("rd_en", en, ok ? (4'b1 << exp_ch) : 4'b0);
      if (ok) begin
        check("data", data, (64'(exp_ch) << 24) | 64'(exp_ptr[exp_ch]));
        exp_ptr[exp_ch]++;
        pops++;
      end
      n++;
    end
    check("pop_total", pops, PKT);
    if (zero_lvls) lvl = '0;
    dreq = 1'b1; empty = '0; g = 0; bad = 0;
    while (g < 40) begin
      @(negedge rd_clk); ready = 1'b1; #1;
      if (!busy) break;
      if (en != 0 || req) bad++;
      g++;
    end
    ready = 1'b0;
    check("gap_len", g, GAP);
    check("gap_quiet", bad, 0);
  endtask

  initial begin
    int w, h;
    rd_rst_n = 1'b0; lvl = '0; empty = '0; ch_enable = 4'hF;
    ready = 1'b0; dreq = 1'b0;
    #2;
    check_zero_outs("reset");
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;

    // Single channel 2 with exactly one packet
    set_lvl(2, 256);
    do_packet(2, 0, -1, 1, w);

    // Masked channel and threshold 255 must not be granted
    ch_enable = 4'b1101; set_lvl(1, 256);
    repeat (10) @(negedge rd_clk);
    #1; check("masked_idle", busy, 0);
    ch_enable = 4'hF; set_lvl(1, 255);
    repeat (10) @(negedge rd_clk);
    #1; check("lvl255_idle", busy, 0);
    check("lvl255_noreq", req, 0);
    @(negedge rd_clk); set_lvl(1, 256);
    do_packet(1, 1, -1, 1, w);
    check("req_latency_le2", (w <= 2), 1);

    // Reset in the middle of a packet on channel 3
    @(negedge rd_clk); set_lvl(3, 256);
    do_packet(3, 0, 100, 1, w);

    // Continuous traffic on all channels: rr restarts at 0
    @(negedge rd_clk);
    for (int c = 0; c < NCH; c++) set_lvl(c, 300);
    do_packet(0, 0, -1, 0, w);
    do_packet(1, 0, -1, 0, w);
    do_packet(2, 0, -1, 0, w);
    do_packet(3, 0, -1, 0, w);
    do_packet(0, 0, -1, 1, w);

`ifdef UDP_TX_SCHED_TIMEOUT_EN
    // Stack never answers channel 1; next grant must move to channel 2
    @(negedge rd_clk); set_lvl(1, 256); set_lvl(2, 256); dreq = 1'b1;
    w = 0;
    while (!req && w < 20) begin @(negedge rd_clk); #1; w++; end
    check("tmo_grant_ch", ch, 1);
    h = 0;
    while (req && h < 40) begin
      check("tmo_no_pop", en, 0);
      @(negedge rd_clk); #1; h++;
    end
    check("tmo_req_cycles", h, 16);
    check("tmo_flag", timeout, 1);
    check("tmo_zero_pops", fifo_ptr[1], exp_ptr[1]);
    do_packet(2, 0, -1, 1, w);
    check("tmo_sticky", timeout, 1);
`else
    h = 0;
    check("timeout_tied", timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
